dbg_cmd_master: RTL

Initiator side of the debug bus (`dbg_intf`): accepts one debug command at a time from a host-side request channel (UART/JTAG bridge), drives it onto the debug bus, waits for the core's done handshake, and returns read data plus status on a response channel. It sits between the host transport and `core_dbg_module`. It owns all bus sequencing: hold, capture, release, and timeout.

---
 rtl/dbg_cmd_master_if.sv | 30 +++
 rtl/dbg_cmd_master.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/dbg_cmd_master_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dbg_intf : debug bus between dbg_cmd_master and the core's debug   |
// |            module (command/address/data out, done/read-data back). |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface dbg_intf;
  logic [7:0]  cmd;
  logic [31:0] addr;
  logic [31:0] data_dbg_dut;
  logic        dut_done;
  logic [31:0] data_dut_dbg;

  modport dbg (
    output cmd,
    output addr,
    output data_dbg_dut,
    input  dut_done,
    input  data_dut_dbg
  );

  modport dut (
    input  cmd,
    input  addr,
    input  data_dbg_dut,
    output dut_done,
    output data_dut_dbg
  );
endinterface
`default_nettype wire

// File: rtl/dbg_cmd_master.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dbg_cmd_master : one-at-a-time debug command initiator that owns   |
// |                  bus hold, capture, release and timeout handling.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module dbg_cmd_master #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  wire         clk,
  input  wire         rstn_i,
  input  wire         req_valid_i,
  output logic        req_ready_o,
  input  wire  [7:0]  req_cmd_i,
  input  wire  [31:0] req_addr_i,
  input  wire  [31:0] req_data_i,
  output logic        rsp_valid_o,
  input  wire         rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic        busy_o,
  dbg_intf.dbg        dbg_bus
);

  localparam int            c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX  = {c_CNT_W{1'b1}};

  localparam logic [7:0] c_CMD_NOP    = 8'h00;
  localparam logic [7:0] c_CMD_RD_REG = 8'h03;
  localparam logic [7:0] c_CMD_RD_PC  = 8'h05;
  localparam logic [7:0] c_CMD_LAST   = 8'h06;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_RELEASE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [7:0]           r_bus_cmd;
  logic [31:0]          r_bus_addr;
  logic [31:0]          r_bus_data;
  logic                 r_req_ready;
  logic                 r_rsp_valid;
  logic [31:0]          r_rsp_data;
  logic                 r_rsp_err;
  logic                 r_busy;

  logic                 w_accept;
  logic                 w_legal;
  logic                 w_is_read;
  logic                 w_cnt_last;
  logic [c_CNT_W-1:0]   w_cnt_inc;

  assign w_accept   = req_valid_i && r_req_ready;
  assign w_legal    = (req_cmd_i != c_CMD_NOP) && (req_cmd_i <= c_CMD_LAST);
  // The bus command register doubles as the latched command while in ISSUE.
  assign w_is_read  = (r_bus_cmd == c_CMD_RD_REG) || (r_bus_cmd == c_CMD_RD_PC);
  assign w_cnt_last = (r_cnt == c_CNT_LAST);
  assign w_cnt_inc  = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bus_cmd   <= c_CMD_NOP;
      r_bus_addr  <= '0;
      r_bus_data  <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_req_ready <= 1'b1;
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_cnt       <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            if (w_legal) begin
              r_bus_cmd  <= req_cmd_i;
              r_bus_addr <= req_addr_i;
              r_bus_data <= req_data_i;
              r_state    <= S_ISSUE;
            end else begin
              // Illegal codes never touch the bus.
              r_rsp_err   <= 1'b1;
              r_rsp_valid <= 1'b1;
              r_state     <= S_RESP;
            end
          end
        end

        S_ISSUE: begin
          if (dbg_bus.dut_done) begin
            r_rsp_data <= w_is_read ? dbg_bus.data_dut_dbg : 32'h0;
            r_cnt      <= '0;
            r_bus_cmd  <= c_CMD_NOP;
            r_bus_addr <= '0;
            r_bus_data <= '0;
            r_state    <= S_RELEASE;
          end else if (w_cnt_last) begin
            r_rsp_err  <= 1'b1;
            r_cnt      <= '0;
            r_bus_cmd  <= c_CMD_NOP;
            r_bus_addr <= '0;
            r_bus_data <= '0;
            r_state    <= S_RELEASE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        // Wait for done to drop so a stale done cannot complete the next command.
        S_RELEASE: begin
          if (!dbg_bus.dut_done) begin
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else if (w_cnt_last) begin
            r_rsp_err   <= 1'b1;
            r_rsp_data  <= '0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        S_RESP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_bus_cmd   <= c_CMD_NOP;
          r_bus_addr  <= '0;
          r_bus_data  <= '0;
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_req_ready <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o          = r_req_ready;
  assign rsp_valid_o          = r_rsp_valid;
  assign rsp_data_o           = r_rsp_data;
  assign rsp_err_o            = r_rsp_err;
  assign busy_o               = r_busy;
  assign dbg_bus.cmd          = r_bus_cmd;
  assign dbg_bus.addr         = r_bus_addr;
  assign dbg_bus.data_dbg_dut = r_bus_data;

endmodule
`default_nettype wire
